serial_frame_deserializer: RTL and testbench
============================================

// Module: serial_frame_deserializer
// PURPOSE
//  Upstream stage of the digital signal decoder. Receives a serial bitstream, MSB first.
//  Finds 8-bit frame alignment from the marker bits (bit7=1, bit0=1) and assembles
//  aligned encoded words for the decoder's 8-bit input.
//  Emits words only while frame lock is held. Flags marker violations per word.
// PARAMETERS
//  LOCK_CNT  3  consecutive good aligned frames needed to declare lock (legal: >=2)
//  LOSS_CNT  2  consecutive bad frames while locked that drop lock (legal: >=1)
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst_n       in   1  synchronous, active-low reset
//  bit_in      in   1  serial data bit, MSB of each frame first
//  bit_valid   in   1  bit_in is valid this cycle; bits are accepted only when high
//  word_out    out  8  aligned encoded word (to decoder encoded_data_in)
//  word_valid  out  1  one-cycle pulse: word_out/frame_err are valid
//  frame_err   out  1  word_out failed the marker check (bit7 & bit0 != 1); qualified by word_valid
//  locked      out  1  high while in LOCKED state
// BEHAVIOUR
//  - Shift register: sr <= {sr[6:0], bit_in} on each accepted bit.
//    Window w = {sr[6:0], bit_in} is evaluated in the same cycle. good = w[7] & w[0].
//  - fill counter: 0..7, saturating, counts accepted bits since reset.
//    A window is complete only when fill==7 and bit_valid=1.
//  - phase counter: 0..7, advances per accepted bit, wraps 7->0.
//    Frame boundary = accepted bit with phase==7.
//  - When bit_valid=0, no state, counter, or shift-register change occurs.
//  - States:
//    HUNT:   every complete window is checked (sliding 1 bit at a time).
//            good -> VERIFY, good_cnt=1, phase=0. bad -> stay.
//    VERIFY: checks only at frame boundaries.
//            good -> good_cnt+1; when it reaches LOCK_CNT -> LOCKED, miss_cnt=0.
//            bad -> HUNT, good_cnt=0 (fill stays saturated, so hunting resumes on the next bit).
//    LOCKED: at each frame boundary, register word_out<=w, frame_err<=~good, word_valid<=1.
//            good -> miss_cnt=0.
//            bad  -> miss_cnt+1; when it reaches LOSS_CNT -> HUNT, good_cnt=0.
//  - No words are emitted in HUNT or VERIFY.
//    The frame that completes lock is not emitted; emission starts with the next frame.
//  - The bad frame that causes loss of lock is still emitted, with frame_err=1.
//    locked falls in the same cycle that word_valid rises.
//  - Latency: word_valid/word_out are registered and appear in the cycle after the
//    bit_valid cycle carrying the frame's last bit. word_valid is never high two cycles in a row.
//  - locked is the registered state decode (state==LOCKED).
//  - Reset values: word_out=8'h00, word_valid=0, frame_err=0, locked=0.
//    state=HUNT; sr, fill, phase, good_cnt, miss_cnt all 0.
//  - Reset mid-frame or while locked aborts everything.
//    A full re-hunt is required: 8 fresh bits, then LOCK_CNT good frames.
//  - Reset has priority over bit_valid in the same cycle.
//  - Counter widths: $clog2(LOCK_CNT+1) and $clog2(LOSS_CNT+1). Neither counter may wrap.
// TESTING
//  1 Reset: hold rst_n=0 with random bits -> word_out=00, word_valid=0, frame_err=0, locked=0.
//  2 Defaults; bits 0,0,0 then repeated 0x81 MSB-first, bit_valid=1 -> locked rises at the
//    end of the 3rd 0x81; following frames give word_out=81, word_valid pulse, frame_err=0.
//  3 Locked; insert one 0x7E between 0x81 frames -> 0x7E emitted with frame_err=1;
//    locked stays 1; next 0x81 gives frame_err=0 (miss_cnt cleared).
//  4 Locked; two consecutive 0x7E -> both emitted with frame_err=1; locked=0 in the
//    second word_valid cycle; no further word_valid until relocked after 3 good frames.
//  5 Test 2 with bit_valid randomly low ~50% of cycles -> identical word_out sequence,
//    each word_valid one cycle wide.
//  6 rst_n=0 for 1 cycle mid-frame while locked -> next cycle locked=0, word_valid=0;
//    resumed 0x81 stream relocks only after 3 full good frames.

Source files
------------

// File: rtl/serial_frame_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_deserializer
// Description : Finds 8-bit frame alignment in an MSB-first bitstream from
//               the bit7/bit0 markers and emits aligned words while locked.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_deserializer #(
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] word_out,
    output logic       word_valid,
    output logic       frame_err,
    output logic       locked
);

    localparam int c_GW = $clog2(LOCK_CNT + 1);
    localparam int c_MW = $clog2(LOSS_CNT + 1);

    localparam logic [c_GW-1:0] c_LOCK_TGT = c_GW'(LOCK_CNT);
    localparam logic [c_MW-1:0] c_LOSS_TGT = c_MW'(LOSS_CNT);

    localparam logic [1:0] c_ST_HUNT   = 2'd0;
    localparam logic [1:0] c_ST_VERIFY = 2'd1;
    localparam logic [1:0] c_ST_LOCKED = 2'd2;

    logic [1:0]      r_state;
    logic [6:0]      r_sr;
    logic [2:0]      r_fill;
    logic [2:0]      r_phase;
    logic [c_GW-1:0] r_good_cnt;
    logic [c_MW-1:0] r_miss_cnt;
    logic [7:0]      r_word_out;
    logic            r_word_valid;
    logic            r_frame_err;

    logic [7:0]      w_window;
    logic            w_good;
    logic            w_complete;
    logic            w_boundary;
    logic [c_GW-1:0] w_good_inc;
    logic [c_MW-1:0] w_miss_inc;

    // Only the last 7 bits are stored; the window adds the bit arriving now.
    assign w_window   = {r_sr, bit_in};
    assign w_good     = w_window[7] & w_window[0];
    assign w_complete = (r_fill == 3'd7);
    assign w_boundary = (r_phase == 3'd7);
    assign w_good_inc = r_good_cnt + 1'b1;
    assign w_miss_inc = r_miss_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_ST_HUNT;
            r_sr         <= 7'd0;
            r_fill       <= 3'd0;
            r_phase      <= 3'd0;
            r_good_cnt   <= '0;
            r_miss_cnt   <= '0;
            r_word_out   <= 8'h00;
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (bit_valid) begin
                r_sr    <= w_window[6:0];
                r_phase <= r_phase + 3'd1;
                if (!w_complete) begin
                    r_fill <= r_fill + 3'd1;
                end
                case (r_state)
                    c_ST_HUNT: begin
                        // Sliding search: restart the frame phase right after a hit.
                        if (w_complete && w_good) begin
                            r_state    <= c_ST_VERIFY;
                            r_good_cnt <= c_GW'(1);
                            r_phase    <= 3'd0;
                        end
                    end
                    c_ST_VERIFY: begin
                        if (w_boundary) begin
                            if (w_good) begin
                                r_good_cnt <= w_good_inc;
                                if (w_good_inc == c_LOCK_TGT) begin
                                    r_state    <= c_ST_LOCKED;
                                    r_miss_cnt <= '0;
                                end
                            end else begin
                                r_state    <= c_ST_HUNT;
                                r_good_cnt <= '0;
                            end
                        end
                    end
                    c_ST_LOCKED: begin
                        if (w_boundary) begin
                            r_word_out   <= w_window;
                            r_frame_err  <= ~w_good;
                            r_word_valid <= 1'b1;
                            if (w_good) begin
                                r_miss_cnt <= '0;
                            end else if (w_miss_inc == c_LOSS_TGT) begin
                                r_state    <= c_ST_HUNT;
                                r_good_cnt <= '0;
                                r_miss_cnt <= '0;
                            end else begin
                                r_miss_cnt <= w_miss_inc;
                            end
                        end
                    end
                    default: begin
                        r_state <= c_ST_HUNT;
                    end
                endcase
            end
        end
    end

    assign word_out   = r_word_out;
    assign word_valid = r_word_valid;
    assign frame_err  = r_frame_err;
    assign locked     = (r_state == c_ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_deserializer
// Description : Directed self-checking bench for serial_frame_deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_deserializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bit_in;
    logic       bit_valid;
    logic [7:0] word_out;
    logic       word_valid;
    logic       frame_err;
    logic       locked;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   wv_cnt  = 0;
    int   dbl_cnt = 0;
    logic prev_wv = 1'b0;
    bit   gaps    = 1'b0;

    always #5 clk = ~clk;

    serial_frame_deserializer #(
        .LOCK_CNT (3),
        .LOSS_CNT (2)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .word_out   (word_out),
        .word_valid (word_valid),
        .frame_err  (frame_err),
        .locked     (locked)
    );

    always @(negedge clk) begin
        if (word_valid) wv_cnt <= wv_cnt + 1;
        if (word_valid && prev_wv) dbl_cnt <= dbl_cnt + 1;
        prev_wv <= word_valid;
    end

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        int n;
        n = gaps ? int'($urandom_range(0, 2)) : 0;
        repeat (n) begin
            @(negedge clk);
            bit_valid = 1'b0;
            bit_in    = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
    endtask

    task automatic chk_frame(input string tag, input logic exp_wv, input logic [7:0] exp_word,
                             input logic exp_err, input logic exp_lock);
        check_eq({tag, "_wv"}, {7'd0, word_valid}, {7'd0, exp_wv});
        if (exp_wv) begin
            check_eq({tag, "_word"}, word_out, exp_word);
            check_eq({tag, "_err"}, {7'd0, frame_err}, {7'd0, exp_err});
        end
        check_eq({tag, "_lock"}, {7'd0, locked}, {7'd0, exp_lock});
    endtask

    task automatic lock_sequence(input string tag);
        int base;
        base = wv_cnt;
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        send_frame(8'h81); chk_frame({tag, "_f1"}, 1'b0, 8'h00, 1'b0, 1'b0);
        send_frame(8'h81); chk_frame({tag, "_f2"}, 1'b0, 8'h00, 1'b0, 1'b0);
        send_frame(8'h81); chk_frame({tag, "_f3"}, 1'b0, 8'h00, 1'b0, 1'b1);
        check_eq({tag, "_nowords"}, 8'(wv_cnt - base), 8'd0);
        for (int k = 0; k < 3; k++) begin
            send_frame(8'h81);
            chk_frame({tag, "_emit"}, 1'b1, 8'h81, 1'b0, 1'b1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        rst_n     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;

        // Reset held with random traffic
        repeat (10) begin
            @(negedge clk);
            bit_in    = 1'($urandom_range(0, 1));
            bit_valid = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        check_eq("rst_word", word_out, 8'h00);
        check_eq("rst_wv", {7'd0, word_valid}, 8'd0);
        check_eq("rst_err", {7'd0, frame_err}, 8'd0);
        check_eq("rst_lock", {7'd0, locked}, 8'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        bit_valid = 1'b0;

        // Acquire lock on a clean 0x81 stream
        lock_sequence("t2");

        // Single bad frame while locked, then a second isolated one
        send_frame(8'h7E); chk_frame("t3_bad1", 1'b1, 8'h7E, 1'b1, 1'b1);
        send_frame(8'h81); chk_frame("t3_good", 1'b1, 8'h81, 1'b0, 1'b1);
        send_frame(8'h7E); chk_frame("t3_bad2", 1'b1, 8'h7E, 1'b1, 1'b1);
        send_frame(8'h81); chk_frame("t3_good2", 1'b1, 8'h81, 1'b0, 1'b1);

        // Two consecutive bad frames drop lock; the first 0x81 after them
        // gives a false hunt hit, so lock returns only at the end of the 4th.
        send_frame(8'h7E); chk_frame("t4_bad1", 1'b1, 8'h7E, 1'b1, 1'b1);
        send_frame(8'h7E); chk_frame("t4_bad2", 1'b1, 8'h7E, 1'b1, 1'b0);
        base = wv_cnt;
        send_frame(8'h81); chk_frame("t4_f1", 1'b0, 8'h00, 1'b0, 1'b0);
        send_frame(8'h81); chk_frame("t4_f2", 1'b0, 8'h00, 1'b0, 1'b0);
        send_frame(8'h81); chk_frame("t4_f3", 1'b0, 8'h00, 1'b0, 1'b0);
        send_frame(8'h81); chk_frame("t4_f4", 1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("t4_nowords", 8'(wv_cnt - base), 8'd1);
        send_frame(8'h81); chk_frame("t4_f5", 1'b1, 8'h81, 1'b0, 1'b1);

        // One-cycle reset mid-frame while locked, with bit_valid asserted
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        @(negedge clk);
        rst_n     = 1'b0;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t6_lock", {7'd0, locked}, 8'd0);
        check_eq("t6_wv", {7'd0, word_valid}, 8'd0);
        check_eq("t6_word", word_out, 8'h00);
        @(negedge clk);
        rst_n     = 1'b1;
        bit_valid = 1'b0;
        base = wv_cnt;
        send_frame(8'h81); chk_frame("t6_f1", 1'b0, 8'h00, 1'b0, 1'b0);
        send_frame(8'h81); chk_frame("t6_f2", 1'b0, 8'h00, 1'b0, 1'b0);
        send_frame(8'h81); chk_frame("t6_f3", 1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("t6_nowords", 8'(wv_cnt - base), 8'd0);
        send_frame(8'h81); chk_frame("t6_f4", 1'b1, 8'h81, 1'b0, 1'b1);

        // Lock sequence again with random bit_valid gaps
        @(negedge clk);
        rst_n     = 1'b0;
        bit_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gaps  = 1'b1;
        lock_sequence("t5");
        gaps = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("wv_single_cycle", 8'(dbl_cnt), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
